// File: rtl/spi_master_param.sv
//==============================================================================
// Module      : spi_master_param
// Description : Parametrised SPI master, one DATA_W word per CS-low frame,
//               valid/ready load, optional MISO receive (macro SPI_MISO_RX_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master_param #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    parameter int CS_IDLE = 2,
    parameter int CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] datain,
    output logic              spi_cs_l,
    output logic              spi_sclk,
    output logic              spi_data,
    input  logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  counter
);

    localparam int c_div_max = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int c_div_w   = $clog2(c_div_max + 1);
    localparam int c_edge_w  = $clog2(2 * DATA_W + 1);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0]  c_gap_last  = c_div_w'(CS_IDLE - 1);
    localparam logic [c_edge_w-1:0] c_edge_last = c_edge_w'(2 * DATA_W);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_lead  = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_tail  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    logic [2:0]          r_state;
    logic [c_div_w-1:0]  r_div;
    logic [c_edge_w-1:0] r_edge;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_tx_ready;
    logic                r_cs_l;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_rx_valid;
    logic                r_busy;
    logic [CNT_W-1:0]    r_counter;

    logic                w_tick;
    logic                w_accept;
    logic                w_in_frame;
    logic [c_edge_w-1:0] w_edge_num;
    logic                w_leading;
    logic                w_sample;
    logic                w_shift;
    logic                w_sample_now;

    // Edge numbering starts at 1, so odd edges are the leading ones.
    assign w_tick       = (r_div == c_div_last);
    assign w_accept     = (r_state == c_st_idle) && tx_valid && r_tx_ready;
    assign w_in_frame   = (r_state == c_st_lead) || (r_state == c_st_shift);
    assign w_edge_num   = r_edge + c_edge_w'(1);
    assign w_leading    = w_edge_num[0];
    assign w_sample     = CPHA ? ~w_leading : w_leading;
    assign w_shift      = CPHA ? w_leading : (~w_leading && (w_edge_num != c_edge_last));
    assign w_sample_now = w_in_frame && w_tick && w_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_div      <= '0;
            r_edge     <= '0;
            r_shreg    <= '0;
            r_tx_ready <= 1'b1;
            r_cs_l     <= 1'b1;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_counter  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_shreg    <= datain;
                        r_counter  <= CNT_W'(DATA_W);
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_cs_l     <= 1'b0;
                        r_div      <= '0;
                        r_edge     <= '0;
                        if (!CPHA) begin
                            r_mosi <= datain[DATA_W-1];
                        end
                        r_state    <= c_st_lead;
                    end
                end
                c_st_lead, c_st_shift: begin
                    if (w_tick) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_num;
                        if (w_sample) begin
                            r_counter <= r_counter - CNT_W'(1);
                        end
                        // CPHA=0 already presented the MSB at accept time.
                        if (w_shift) begin
                            r_mosi  <= CPHA ? r_shreg[DATA_W-1] : r_shreg[DATA_W-2];
                            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                        end
                        r_state <= (w_edge_num == c_edge_last) ? c_st_tail : c_st_shift;
                    end else begin
                        r_div <= r_div + c_div_w'(1);
                    end
                end
                c_st_tail: begin
                    if (w_tick) begin
                        r_div      <= '0;
                        r_cs_l     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_valid <= 1'b1;
                        r_state    <= c_st_gap;
                    end else begin
                        r_div <= r_div + c_div_w'(1);
                    end
                end
                c_st_gap: begin
                    if (r_div == c_gap_last) begin
                        r_div      <= '0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= c_st_idle;
                    end else begin
                        r_div <= r_div + c_div_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef SPI_MISO_RX_EN
    logic [DATA_W-1:0] r_rxsh;
    logic [DATA_W-1:0] r_rx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxsh    <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_sample_now) begin
                r_rxsh <= {r_rxsh[DATA_W-2:0], spi_miso};
            end
            if ((r_state == c_st_tail) && w_tick) begin
                r_rx_data <= r_rxsh;
            end
        end
    end

    assign rx_data = r_rx_data;
`else
    logic w_unused_rx;
    assign w_unused_rx = spi_miso ^ w_sample_now;
    assign rx_data     = '0;
`endif

    assign tx_ready = r_tx_ready;
    assign spi_cs_l = r_cs_l;
    assign spi_sclk = r_sclk;
    assign spi_data = r_mosi;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign counter  = r_counter;

endmodule

`default_nettype wire
